// File: rtl/ibuf_pkg.sv
// Shared types and sizing for the instruction-buffer flow controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ibuf_pkg;

  localparam int DEPTH        = 8;  // buffer entries (pairs) per FIFO lane
  localparam int CNT_W        = 4;  // occupancy width, holds 0..DEPTH
  localparam int MAX_INFLIGHT = 4;  // outstanding fetch request limit
  localparam int INF_W        = 3;  // in-flight / drop width, holds 0..MAX_INFLIGHT

  typedef enum logic {
    RUN  = 1'b0,  // normal operation
    DROP = 1'b1   // discarding fetch returns that were in flight at a flush
  } state_t;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with synchronous clear.
// Latency: count updates on the clock edge after inc/dec; o_ovf is combinational.
// Backpressure: none; o_ovf flags an increment that would pass MAX.
// Ports: clk, rst (async, active-high); i_clr sync clear; i_inc/i_dec step
//        requests (both together hold); o_cnt current count; o_ovf overflow.
module sat_updown_cnt #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_ovf
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_ovf = i_inc & ~i_dec & (r_cnt == MAXV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc & ~i_dec) begin
      if (r_cnt != MAXV) r_cnt <= r_cnt + W'(1);
    end else if (i_dec & ~i_inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/ibuf_flow_ctrl.sv
// Credit-based flow controller for the dual-lane instruction buffer.
// Latency: push/pop/flush gating is combinational; counters update on the next edge.
// Backpressure: fetch_stall refuses fetch when credits (occupancy+inflight) or the
//               in-flight limit are exhausted, during a flush, and while dropping.
// Ports: clk, rst (async, active-high); flush_in, fetch_req, inst_valid_in,
//        decode_ready inputs; fetch_stall, buf_push_en, buf_pop_en, buf_flush,
//        buf_valid strobes; occupancy, inflight counts; proto_err sticky flag.
module ibuf_flow_ctrl
  import ibuf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_in,
  input  logic             fetch_req,
  output logic             fetch_stall,
  input  logic             inst_valid_in,
  input  logic             decode_ready,
  output logic             buf_push_en,
  output logic             buf_pop_en,
  output logic             buf_flush,
  output logic             buf_valid,
  output logic [CNT_W-1:0] occupancy,
  output logic [INF_W-1:0] inflight,
  output logic             proto_err
);

  state_t           r_state, w_state_nxt;
  logic [INF_W-1:0] r_drop_cnt, w_drop_nxt;
  logic [INF_W-1:0] w_outstanding;
  logic [CNT_W:0]   w_credit;
  logic             w_run, w_fire, w_ret, w_pop, w_unexp;
  logic             w_occ_ovf, w_inf_ovf;
  logic             r_proto_err;

  assign w_run = (r_state == RUN);

  // Credit sum one bit wider than occupancy so it cannot wrap.
  assign w_credit = {1'b0, occupancy} + {{(CNT_W + 1 - INF_W){1'b0}}, inflight};

  assign fetch_stall = rst | flush_in | ~w_run
                     | (w_credit >= (CNT_W + 1)'(DEPTH))
                     | (inflight == INF_W'(MAX_INFLIGHT));
  assign w_fire = fetch_req & ~fetch_stall;

  // A return only counts when a request is actually outstanding.
  assign w_ret   = inst_valid_in & w_run & ~flush_in & (inflight != '0) & ~rst;
  assign w_pop   = decode_ready & (occupancy != '0) & w_run & ~flush_in & ~rst;
  assign w_unexp = inst_valid_in & w_run & (inflight == '0);

  // An overflowing return is dropped rather than pushed into a full lane.
  assign buf_push_en = w_ret & ~w_occ_ovf;
  assign buf_pop_en  = w_pop;
  assign buf_valid   = w_pop;
  assign buf_flush   = flush_in & ~rst;
  assign proto_err   = r_proto_err;

  sat_updown_cnt #(.W(CNT_W), .MAX(DEPTH)) u_occ_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush_in),
    .i_inc (w_ret),
    .i_dec (w_pop),
    .o_cnt (occupancy),
    .o_ovf (w_occ_ovf)
  );

  sat_updown_cnt #(.W(INF_W), .MAX(MAX_INFLIGHT)) u_inf_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush_in),
    .i_inc (w_fire),
    .i_dec (w_ret),
    .o_cnt (inflight),
    .o_ovf (w_inf_ovf)
  );

  // Requests still owed a return: tracked by inflight in RUN, by drop_cnt in DROP.
  assign w_outstanding = w_run ? inflight : r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    if (flush_in) begin
      // A return arriving on the flush edge is already accounted for.
      if (w_outstanding != '0) w_drop_nxt = w_outstanding - INF_W'(inst_valid_in);
      else                     w_drop_nxt = '0;
      w_state_nxt = (w_drop_nxt != '0) ? DROP : RUN;
    end else if (!w_run && inst_valid_in) begin
      w_drop_nxt = r_drop_cnt - INF_W'(1);
      if (w_drop_nxt == '0) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (w_unexp | w_occ_ovf | w_inf_ovf) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibuf_flow_ctrl.sv
// Self-checking bench for ibuf_flow_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a counter-level behavioural model.
// Ports of the DUT are all driven/observed here.
module tb_ibuf_flow_ctrl;

  localparam int DEPTH = 8;
  localparam int MAXI  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_in = 1'b0, fetch_req = 1'b0, inst_valid_in = 1'b0, decode_ready = 1'b0;
  logic       fetch_stall, buf_push_en, buf_pop_en, buf_flush, buf_valid, proto_err;
  logic [3:0] occupancy;
  logic [2:0] inflight;

  int n_pass  = 0;
  int n_total = 0;

  // model: counts after the most recent edge
  int m_occ = 0, m_inf = 0, m_drop = 0;
  bit m_dropst = 1'b0, m_perr = 1'b0;

  ibuf_flow_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush_in      (flush_in),
    .fetch_req     (fetch_req),
    .fetch_stall   (fetch_stall),
    .inst_valid_in (inst_valid_in),
    .decode_ready  (decode_ready),
    .buf_push_en   (buf_push_en),
    .buf_pop_en    (buf_pop_en),
    .buf_flush     (buf_flush),
    .buf_valid     (buf_valid),
    .occupancy     (occupancy),
    .inflight      (inflight),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Compare process: outputs are checked mid-cycle, then the model advances
  // to the state the coming edge must produce.
  int  c_out, c_nd;
  bit  e_stall, e_push, e_pop, e_fire;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_stall", fetch_stall, 1);
      check("rst_push", buf_push_en, 0);
      check("rst_pop", buf_pop_en, 0);
      check("rst_valid", buf_valid, 0);
      check("rst_flush", buf_flush, 0);
      check("rst_occ", occupancy, 0);
      check("rst_inf", inflight, 0);
      check("rst_perr", proto_err, 0);
      m_occ = 0; m_inf = 0; m_drop = 0; m_dropst = 0; m_perr = 0;
    end else begin
      e_stall = flush_in || m_dropst || (m_occ + m_inf >= DEPTH) || (m_inf == MAXI);
      e_push  = inst_valid_in && !m_dropst && !flush_in && (m_inf > 0);
      e_pop   = decode_ready && (m_occ > 0) && !m_dropst && !flush_in;
      e_fire  = fetch_req && !e_stall;
      check("stall", fetch_stall, e_stall);
      check("push", buf_push_en, e_push);
      check("pop", buf_pop_en, e_pop);
      check("valid", buf_valid, e_pop);
      check("flush", buf_flush, flush_in);
      check("occ", occupancy, m_occ);
      check("inf", inflight, m_inf);
      check("perr", proto_err, m_perr);
      if (inst_valid_in && !m_dropst && m_inf == 0) m_perr = 1;
      if (flush_in) begin
        c_out = m_dropst ? m_drop : m_inf;
        c_nd  = (c_out > 0) ? c_out - int'(inst_valid_in) : 0;
        m_occ = 0; m_inf = 0; m_drop = c_nd; m_dropst = (c_nd != 0);
      end else if (m_dropst) begin
        if (inst_valid_in) begin
          m_drop--;
          if (m_drop == 0) m_dropst = 0;
        end
      end else begin
        m_occ = m_occ + int'(e_push) - int'(e_pop);
        m_inf = m_inf + int'(e_fire) - int'(e_push);
      end
    end
  end

  task automatic step(input bit rq, input bit v, input bit dr, input bit fl);
    @(posedge clk); #1;
    rst = 0; fetch_req = rq; inst_valid_in = v; decode_ready = dr; flush_in = fl;
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; fetch_req = 0; inst_valid_in = 0; decode_ready = 0; flush_in = 0;
    @(negedge clk); #2;
  endtask

  int fires;
  int vprob, drprob, outst;
  bit rq, v, dr, fl;

  initial begin
    // Credit limit from in-flight cap: 4 fires then stall.
    do_reset();
    fires = 0;
    repeat (6) begin
      step(1, 0, 0, 0);
      if (!fetch_stall) fires++;
    end
    check("s1_fires", fires, 4);
    check("s1_inflight", inflight, 4);
    check("s1_stall", fetch_stall, 1);

    // Returns keep pace, decode blocked: buffer fills to DEPTH.
    do_reset();
    repeat (20) step(1, m_inf > 0, 0, 0);
    check("s2_occ", occupancy, 8);
    check("s2_inf", inflight, 0);
    check("s2_stall", fetch_stall, 1);

    // Simultaneous push and pop with occupancy 3, inflight 1.
    do_reset();
    step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    step(0, 1, 1, 0);
    check("s3_valid", buf_valid, 1);
    check("s3_push", buf_push_en, 1);
    step(0, 0, 0, 0);
    check("s3_occ", occupancy, 3);
    check("s3_inf", inflight, 0);

    // Flush with occupancy 5, inflight 3, then three stale returns.
    do_reset();
    step(1, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("s4_pre_occ", occupancy, 5);
    check("s4_pre_inf", inflight, 3);
    check("s4_bflush", buf_flush, 1);
    step(0, 1, 0, 0);
    check("s4_occ0", occupancy, 0);
    check("s4_drop_stall", fetch_stall, 1);
    check("s4_push1", buf_push_en, 0);
    step(0, 1, 0, 0);
    check("s4_push2", buf_push_en, 0);
    step(0, 1, 0, 0);
    check("s4_push3", buf_push_en, 0);
    check("s4_stall3", fetch_stall, 1);
    step(0, 0, 0, 0);
    check("s4_resume", fetch_stall, 0);

    // Flush coincident with a return.
    do_reset();
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    check("s5_inf2", inflight, 2);
    check("s5_push", buf_push_en, 0);
    step(0, 0, 0, 0);
    check("s5_drop", fetch_stall, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("s5_run", fetch_stall, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    check("s5_inf1", inflight, 1);
    step(0, 0, 0, 0);
    check("s5_direct_run", fetch_stall, 0);

    // Unexpected return with nothing outstanding.
    do_reset();
    step(0, 1, 0, 0);
    check("s6_push", buf_push_en, 0);
    step(0, 0, 0, 0);
    check("s6_perr", proto_err, 1);
    repeat (5) step(1, 0, 1, 0);
    check("s6_sticky", proto_err, 1);

    // Randomized traffic in three phases of differing return/drain pressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vprob  = (i < 1000) ? 70 : (i < 2000) ? 50 : 30;
      drprob = (i < 1000) ? 20 : (i < 2000) ? 90 : 50;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        outst = m_dropst ? m_drop : m_inf;
        rq = ($urandom_range(0, 3) != 0);
        if (outst > 0) v = ($urandom_range(0, 99) < vprob);
        else           v = ($urandom_range(0, 299) == 0);
        dr = ($urandom_range(0, 99) < drprob);
        fl = ($urandom_range(0, 39) == 0);
        step(rq, v, dr, fl);
      end
    end

    do_reset();
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibuf_flow_ctrl.md
Name: ibuf_flow_ctrl

Overview:
Flow controller that sequences the dual-lane instruction buffer (two paired FIFOs, one fetch pair per entry) between the fetch stage and decode. Tracks buffer occupancy and outstanding fetch requests, and throttles fetch by credit so the buffer can never overflow. Gates pushes and pops, and sequences a flush, including discarding stale fetch returns that were in flight at the flush.

Parameters:
DEPTH, 8, buffer entries (pairs) per FIFO lane
CNT_W, 4, width of the occupancy counter; must hold 0..DEPTH
MAX_INFLIGHT, 4, maximum outstanding fetch requests
INF_W, 3, width of the in-flight and drop counters; must hold 0..MAX_INFLIGHT

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush_in  in  1  backend redirect; flush the buffer
fetch_req  in  1  fetch wants to issue a pair request this cycle
fetch_stall  out  1  fetch request refused this cycle
inst_valid_in  in  1  fetch returns one instruction pair
decode_ready  in  1  decode can accept one pair
buf_push_en  out  1  push enable to both buffer lanes
buf_pop_en  out  1  pop request (get_data_req) to both lanes
buf_flush  out  1  flush to both lanes
buf_valid  out  1  popped pair valid to decode
occupancy  out  CNT_W  current buffer entries
inflight  out  INF_W  outstanding fetch requests
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=RUN, occupancy=0, inflight=0, drop_cnt=0, proto_err=0.
- Reset outputs: all combinational outputs are 0 while rst is high, except fetch_stall=1.
- States: RUN (normal operation) and DROP (discarding stale returns).
- fetch_stall = rst | flush_in | state!=RUN | (occupancy+inflight >= DEPTH) | (inflight == MAX_INFLIGHT).
- The credit sum occupancy+inflight is computed at width CNT_W+1 with no wrap.
- fetch_fire = fetch_req & !fetch_stall.
- buf_push_en = inst_valid_in & state==RUN & !flush_in & inflight!=0. Combinational, same cycle.
- buf_pop_en = buf_valid = decode_ready & occupancy!=0 & state==RUN & !flush_in. The FIFOs present data the same cycle.
- RUN counter updates:
  - occupancy += buf_push_en - buf_pop_en.
  - inflight += fetch_fire - buf_push_en.
  - A simultaneous push and pop leaves occupancy unchanged.
- Protocol violations (no FIFO push in either case):
  - inst_valid_in in RUN with inflight==0: proto_err <= 1; occupancy and inflight unchanged.
  - A push that would make occupancy exceed DEPTH: proto_err <= 1, occupancy saturates at DEPTH. This is unreachable when fetch honours fetch_stall.
- Flush (any state):
  - buf_flush = flush_in, combinational, so the lanes clear on the same edge.
  - At that edge: occupancy <= 0, inflight <= 0, and drop_cnt <= (current outstanding) − inst_valid_in.
  - Current outstanding is inflight in RUN and drop_cnt in DROP.
  - Next state is DROP if the new drop_cnt != 0, else RUN.
- DROP:
  - No push, pop or fetch. Each inst_valid_in decrements drop_cnt.
  - The state returns to RUN on the edge where drop_cnt reaches 0. fetch_stall deasserts the following cycle.
  - inst_valid_in while drop_cnt==0 cannot occur in DROP, since the state has already left.
- Reset mid-operation: all counters clear immediately, and pending returns are not tracked. The fetch unit is reset alongside this block.
- proto_err clears only on rst.

Decomposition:
- Package ibuf_pkg holds the state enum (RUN, DROP), DEPTH, MAX_INFLIGHT, CNT_W and INF_W.
- One sub-module is natural: sat_updown_cnt, a saturating up/down counter with synchronous clear. It is instantiated twice, for occupancy and inflight.
- The FSM, drop_cnt and gating logic stay in the top module.

Test Plan:
- Reset release, fetch_req=1, no returns -> 4 fires on cycles 1-4, then fetch_stall=1 with inflight=4.
- decode_ready=0, returns keep pace with fetch -> occupancy climbs to 8, fetch_stall=1 once occupancy+inflight=8, no further fetch_fire.
- occupancy=3, inflight=1, inst_valid_in=1 and decode_ready=1 same cycle -> occupancy stays 3, inflight=0, buf_valid=1.
- occupancy=5, inflight=3, pulse flush_in -> buf_flush=1 that cycle; next cycle occupancy=0, state=DROP, drop_cnt=3. Three returns produce no buf_push_en. After the third, state=RUN and fetch_stall=0 the next cycle.
- flush_in coincident with inst_valid_in, inflight=2 -> drop_cnt=1, and that return is not pushed. With inflight=1 -> next state RUN directly.
- inst_valid_in=1 in RUN with inflight=0 -> buf_push_en=0, proto_err=1 and it stays 1 until rst.
